sdram_port_arbiter: RTL and testbench

Slot-synchronous arbiter that shares the single 8-bit SDRAM controller port between the ROM/program downloader, the RAM eraser and the Z80 CPU. It replaces the combinational source mux in front of `sdram`. It grants exactly one requester per `clkref` slot and latches that requester's payload for the whole slot. It returns a request-accepted strobe to the requester, plus read data for CPU reads.

---
 rtl/sdram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Slot-synchronous arbiter sharing the single SDRAM controller port between the
// downloader, the RAM eraser and the CPU; one grant per clkref slot, payload held for the slot.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              clkref,

    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_ack,

    input  logic              er_req,
    input  logic [ADDR_W-1:0] er_addr,
    input  logic [7:0]        er_data,
    output logic              er_ack,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    output logic              cpu_rvalid,

    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_oe,
    input  logic [7:0]        sd_dout,

    output logic [1:0]        owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnDl   = 2'd1,
        OwnEr   = 2'd2,
        OwnCpu  = 2'd3
    } owner_e;

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    state_e     state_q;
    owner_e     owner_q;
    owner_e     winner;
    logic       ref_q;
    logic       slot_start;
    logic       first_q;
    logic [3:0] starve_q;
    logic       starved;

    assign slot_start = clkref & ~ref_q;
    assign starved    = (starve_q == 4'(STARVE_MAX));
    assign owner      = owner_q;

    always_comb begin
        winner = OwnNone;
        if (dl_req) begin
            winner = OwnDl;
        end else if (cpu_req && starved) begin
            winner = OwnCpu;
        end else if (er_req) begin
            winner = OwnEr;
        end else if (cpu_req) begin
            winner = OwnCpu;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= StIdle;
            owner_q    <= OwnNone;
            ref_q      <= 1'b0;
            first_q    <= 1'b0;
            starve_q   <= 4'd0;
            busy       <= 1'b0;
            sd_addr    <= '0;
            sd_din     <= 8'h00;
            sd_we      <= 1'b0;
            sd_oe      <= 1'b0;
            dl_ack     <= 1'b0;
            er_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_dout   <= 8'h00;
            cpu_rvalid <= 1'b0;
        end else begin
            ref_q      <= clkref;
            first_q    <= 1'b0;
            cpu_rvalid <= 1'b0;
            // Ack trails the grant edge by one cycle, once the payload is visibly latched.
            dl_ack     <= first_q && (owner_q == OwnDl);
            er_ack     <= first_q && (owner_q == OwnEr);
            cpu_ack    <= first_q && (owner_q == OwnCpu);

            if (slot_start) begin
                // The slot that is ending may be a CPU read whose data is valid now.
                if (state_q == StActive && owner_q == OwnCpu && sd_oe) begin
                    cpu_dout   <= sd_dout;
                    cpu_rvalid <= 1'b1;
                end

                owner_q <= winner;
                busy    <= (winner != OwnNone);
                first_q <= (winner != OwnNone);
                state_q <= (winner != OwnNone) ? StActive : StIdle;

                unique case (winner)
                    OwnDl: begin
                        sd_addr <= dl_addr;
                        sd_din  <= dl_data;
                        sd_we   <= 1'b1;
                        sd_oe   <= 1'b1;
                    end
                    OwnEr: begin
                        sd_addr <= er_addr;
                        sd_din  <= er_data;
                        sd_we   <= 1'b1;
                        sd_oe   <= 1'b1;
                    end
                    OwnCpu: begin
                        sd_addr <= ADDR_W'(cpu_addr);
                        sd_din  <= cpu_din;
                        sd_we   <= cpu_we;
                        sd_oe   <= ~cpu_we;
                    end
                    default: begin
                        sd_we <= 1'b0;
                        sd_oe <= 1'b0;
                    end
                endcase

                // Downloader grants leave the count alone so the CPU keeps its place.
                if (winner == OwnCpu || !cpu_req) begin
                    starve_q <= 4'd0;
                end else if (winner == OwnEr && !starved) begin
                    starve_q <= starve_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected grants are queued at each slot start
// and compared against the latched port, acks and CPU read data over the slot.
module tb_sdram_port_arbiter;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              res_n = 1'b1;
    logic              clkref = 1'b0;
    logic              dl_req = 1'b0;
    logic [ADDR_W-1:0] dl_addr = '0;
    logic [7:0]        dl_data = 8'h00;
    logic              dl_ack;
    logic              er_req = 1'b0;
    logic [ADDR_W-1:0] er_addr = '0;
    logic [7:0]        er_data = 8'h00;
    logic              er_ack;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [15:0]       cpu_addr = 16'h0000;
    logic [7:0]        cpu_din = 8'h00;
    logic              cpu_ack;
    logic [7:0]        cpu_dout;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] sd_addr;
    logic [7:0]        sd_din;
    logic              sd_we;
    logic              sd_oe;
    logic [7:0]        sd_dout;
    logic [1:0]        owner;
    logic              busy;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h66;
    endfunction

    assign sd_dout = mem_byte(sd_addr);

    sdram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .clkref     (clkref),
        .dl_req     (dl_req),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_ack     (dl_ack),
        .er_req     (er_req),
        .er_addr    (er_addr),
        .er_data    (er_data),
        .er_ack     (er_ack),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_ack    (cpu_ack),
        .cpu_dout   (cpu_dout),
        .cpu_rvalid (cpu_rvalid),
        .sd_addr    (sd_addr),
        .sd_din     (sd_din),
        .sd_we      (sd_we),
        .sd_oe      (sd_oe),
        .sd_dout    (sd_dout),
        .owner      (owner),
        .busy       (busy)
    );

    typedef struct packed {
        logic [1:0]        owner;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
        logic              we;
        logic              oe;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              cur = '0;
    logic [7:0]        rd_q[$];
    logic [7:0]        last_dout = 8'h00;
    logic [1:0]        owner_log[$];
    logic [ADDR_W-1:0] addr_log[$];
    int unsigned       n_checks = 0;
    int unsigned       n_pass = 0;
    int unsigned       phase = 7;
    int unsigned       starve_m = 0;
    bit                model_on = 1'b0;
    bit                dl_hold = 1'b0;
    bit                er_hold = 1'b0;
    bit                cpu_hold = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [2:0] ack_of(input logic [1:0] o);
        case (o)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] pack(input logic [1:0] o, input logic b, input logic we,
                                         input logic oe, input logic [ADDR_W-1:0] a,
                                         input logic [7:0] d, input logic [2:0] acks);
        return 64'({o, b, we, oe, a, d, acks});
    endfunction

    // Reference arbitration on the request levels seen in the slot_start cycle.
    task automatic model_grant();
        exp_t e;
        e = '0;
        if (dl_req) begin
            e.owner = 2'd1; e.addr = dl_addr; e.din = dl_data; e.we = 1'b1; e.oe = 1'b1;
        end else if (cpu_req && (starve_m == STARVE_MAX || !er_req)) begin
            e.owner = 2'd3; e.addr = ADDR_W'(cpu_addr); e.din = cpu_din;
            e.we = cpu_we; e.oe = !cpu_we;
        end else if (er_req) begin
            e.owner = 2'd2; e.addr = er_addr; e.din = er_data; e.we = 1'b1; e.oe = 1'b1;
        end
        if (!cpu_req || e.owner == 2'd3) starve_m = 0;
        else if (e.owner == 2'd2 && starve_m < STARVE_MAX) starve_m++;
        exp_q.push_back(e);
    endtask

    task automatic check_cycle();
        logic [63:0] got;
        logic [63:0] want;
        bit          idle;
        if (phase == 1) begin
            if (rd_q.size() != 0) begin
                last_dout = rd_q.pop_front();
                check_eq("rvalid", 64'({cpu_rvalid, cpu_dout}), 64'({1'b1, last_dout}));
            end else begin
                check_eq("no_rvalid", 64'({cpu_rvalid, cpu_dout}), 64'({1'b0, last_dout}));
            end
            check_eq("sb_depth", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            if (cur.owner == 2'd3 && !cur.we) rd_q.push_back(mem_byte(cur.addr));
            owner_log.push_back(owner);
            addr_log.push_back(sd_addr);
        end
        idle = (cur.owner == 2'd0);
        got  = pack(owner, busy, sd_we, sd_oe, idle ? '0 : sd_addr, idle ? 8'h00 : sd_din,
                    {dl_ack, er_ack, cpu_ack});
        want = pack(cur.owner, !idle, cur.we, cur.oe, idle ? '0 : cur.addr,
                    idle ? 8'h00 : cur.din, (phase == 2) ? ack_of(cur.owner) : 3'b000);
        check_eq((phase == 1) ? "grant" : (phase == 2) ? "ack" : "hold", got, want);
        if (phase == 2) begin
            check_eq("rvalid_pulse", 64'(cpu_rvalid), 64'd0);
            if (dl_ack) begin
                if (dl_hold) begin dl_addr++; dl_data++; end
                else dl_req = 1'b0;
            end
            if (er_ack) begin
                if (er_hold) begin er_addr++; er_data++; end
                else er_req = 1'b0;
            end
            if (cpu_ack) begin
                if (cpu_hold) begin cpu_addr++; cpu_din++; end
                else cpu_req = 1'b0;
            end
        end
    endtask

    // clkref is high for phases 0..3, so phase 0 is the slot_start cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        phase  = (phase + 1) % 8;
        clkref = (phase < 4);
        if (model_on) begin
            if (phase == 0) model_grant();
            else check_cycle();
        end
    endtask

    task automatic run_slots(input int n);
        repeat (8 * n) cycle();
    endtask

    task automatic release_reset();
        while (phase != 4) cycle();
        res_n = 1'b1;
        while (phase != 7) cycle();
        exp_q.delete();
        rd_q.delete();
        starve_m  = 0;
        last_dout = 8'h00;
        cur       = '0;
        model_on  = 1'b1;
    endtask

    task automatic check_seq(input string tag, input logic [1:0] seq[$]);
        check_eq({tag, "_len"}, 64'(owner_log.size()), 64'(seq.size()));
        for (int i = 0; i < seq.size() && i < owner_log.size(); i++)
            check_eq(tag, 64'(owner_log[i]), 64'(seq[i]));
    endtask

    initial begin
        logic [1:0]        seq[$];
        logic [ADDR_W-1:0] base;

        // Reset held with every requester asserting.
        #2 res_n = 1'b0;
        dl_req = 1'b1; dl_addr = 25'h1ABCDE; dl_data = 8'h3C;
        er_req = 1'b1; er_addr = 25'h0055AA; er_data = 8'h77;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_din = 8'h99;
        repeat (12) cycle();
        check_eq("reset_outs", 64'({owner, busy, sd_we, sd_oe, sd_addr, sd_din, dl_ack, er_ack,
                                   cpu_ack, cpu_rvalid, cpu_dout}), 64'd0);
        release_reset();
        run_slots(1);
        er_req = 1'b0; cpu_req = 1'b0;

        // CPU read, then CPU write.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8241; cpu_din = 8'h11;
        run_slots(2);
        check_eq("read_a5", 64'(cpu_dout), 64'h0A5);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_din = 8'hE7;
        run_slots(2);

        // Priority, then eraser/CPU starvation rotation.
        owner_log.delete();
        dl_req = 1'b1; dl_hold = 1'b1; dl_addr = 25'h0000100; dl_data = 8'h01;
        er_req = 1'b1; er_hold = 1'b1; er_addr = 25'h0002000; er_data = 8'h40;
        cpu_req = 1'b1; cpu_hold = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        run_slots(3);
        dl_req = 1'b0; dl_hold = 1'b0;
        run_slots(10);
        seq = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        check_seq("prio_seq", seq);
        er_req = 1'b0; er_hold = 1'b0; cpu_req = 1'b0; cpu_hold = 1'b0;
        run_slots(1);

        // Back-to-back eraser writes.
        owner_log.delete();
        addr_log.delete();
        base = 25'h0100000;
        er_req = 1'b1; er_hold = 1'b1; er_addr = base; er_data = 8'h00;
        run_slots(16);
        er_req = 1'b0; er_hold = 1'b0;
        check_eq("b2b_len", 64'(addr_log.size()), 64'd16);
        for (int i = 0; i < 16 && i < addr_log.size(); i++) begin
            check_eq("b2b_addr", 64'(addr_log[i]), 64'(base + ADDR_W'(i)));
            check_eq("b2b_owner", 64'(owner_log[i]), 64'd2);
        end
        run_slots(1);

        // Reset three cycles into a CPU read slot.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00F0; cpu_din = 8'h00;
        repeat (4) cycle();
        #1 res_n = 1'b0;
        model_on = 1'b0;
        #1 check_eq("reset_abort", 64'({owner, busy, sd_we, sd_oe, dl_ack, er_ack, cpu_ack,
                                        cpu_rvalid, cpu_dout}), 64'd0);
        cpu_req = 1'b0;
        release_reset();
        run_slots(1);

        // Starvation count restarts from zero after the reset.
        owner_log.delete();
        er_req = 1'b1; er_hold = 1'b1; er_addr = 25'h0003000;
        cpu_req = 1'b1; cpu_hold = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0500;
        run_slots(5);
        er_req = 1'b0; er_hold = 1'b0; cpu_req = 1'b0; cpu_hold = 1'b0;
        seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        check_seq("post_reset_seq", seq);
        run_slots(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
